// File: rtl/inbox_fifo.sv
// +--------------------------------------------------------------------------+
// | inbox_fifo : first-word-fall-through FIFO feeding the CPU INBOX source   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module inbox_fifo #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_data,
  input  logic          i_wr,
  output logic          o_full,
  input  logic          i_rd,
  output logic [7:0]    o_data,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_udf
);

  localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   C_CNT_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push, pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == C_CNT_DEPTH);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;
  // Empty forces zero so the consumer never sees stale or uninitialised storage.
  assign o_data  = o_empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    // A pop frees the slot this cycle, so a push while full is still taken.
    push     = i_wr && (!o_full || i_rd);
    pop      = i_rd && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (i_wr && o_full && !i_rd);
    udf_d    = udf_q | (i_rd && o_empty);
    if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    if (push && !pop)      count_d = count_q + C_CNT_ONE;
    else if (pop && !push) count_d = count_q - C_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= i_data;
  end

`ifndef SYNTHESIS
  a_count_max : assert property (@(posedge clk) disable iff (rst) count_q <= C_CNT_DEPTH);
  a_empty     : assert property (@(posedge clk) disable iff (rst) o_empty == (count_q == '0));
  a_ptr_diff  : assert property (@(posedge clk) disable iff (rst)
                                 (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
  a_data_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(^o_data));
`endif

endmodule

`default_nettype wire
